// File: rtl/mac_ofm_writer.sv
// mac_ofm_writer: packs the fp32 result stream from the psum accumulator into LANES-wide write beats.
// Latency: 1 cycle from acceptance of the element that closes a beat to o_wr_valid.
// Backpressure: a closed beat holds its data, address and mask until i_wr_ready. o_ofm_ready is low while the beat waits.
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_start, i_base_addr   one-cycle job start and job base byte address (both sampled in IDLE only)
//   i_ofm_valid/o_ofm_ready/i_ofm_data   result element stream; .output_end flags the last element of the job
//   o_wr_valid/i_wr_ready  write beat handshake; o_wr_addr, o_wr_data and o_wr_mask form the beat
//   o_done                 one-cycle pulse after the final beat of a job is accepted
//   o_beat_count           beats accepted in the current or last job

package mac_ofm_pkg;
    typedef struct packed {
        logic        output_end;
        logic [31:0] data;
    } mac_lane_ofm_port;
endpackage

module mac_ofm_writer
    import mac_ofm_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_base_addr,
    output logic                  o_ofm_ready,
    input  logic                  i_ofm_valid,
    input  mac_lane_ofm_port      i_ofm_data,
    output logic                  o_wr_valid,
    input  logic                  i_wr_ready,
    output logic [ADDR_W-1:0]     o_wr_addr,
    output logic [32*LANES-1:0]   o_wr_data,
    output logic [LANES-1:0]      o_wr_mask,
    output logic                  o_done,
    output logic [CNT_W-1:0]      o_beat_count
);

    localparam int              LW         = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int              BEAT_SHIFT = $clog2(LANES * 4);
    localparam logic [LW-1:0]   LAST_LANE  = LW'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic [32*LANES-1:0]   data_q, data_d;
    logic [LANES-1:0]      mask_q, mask_d;
    logic                  wr_vld_q, wr_vld_d;
    logic                  done_q, done_d;

    logic                  ofm_rdy;
    logic                  elem_acc;
    logic                  beat_acc;
    logic                  beat_close;

    // A closed beat only blocks new elements if memory is not taking it this
    // cycle; when it is, the incoming element starts the next beat with no bubble.
    assign ofm_rdy    = (state_q == S_RUN) && (!wr_vld_q || i_wr_ready);
    assign elem_acc   = i_ofm_valid && ofm_rdy;
    assign beat_acc   = wr_vld_q && i_wr_ready;
    assign beat_close = elem_acc && ((lane_q == LAST_LANE) || i_ofm_data.output_end);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        lane_d   = lane_q;
        data_d   = data_q;
        mask_d   = mask_q;
        wr_vld_d = wr_vld_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    base_d   = i_base_addr;
                    cnt_d    = '0;
                    lane_d   = '0;
                    data_d   = '0;
                    mask_d   = '0;
                    wr_vld_d = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (elem_acc && i_ofm_data.output_end) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The output_end element always closes a beat, so the beat
                // waiting here is the last one of the job.
                if (beat_acc) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Retiring a beat clears the data and mask. Any element accepted in the
        // same cycle is then written into an empty beat at lane 0.
        if (beat_acc) begin
            cnt_d    = cnt_q + CNT_W'(1);
            wr_vld_d = 1'b0;
            data_d   = '0;
            mask_d   = '0;
        end

        if (elem_acc) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_q == LW'(k)) begin
                    data_d[32*k +: 32] = i_ofm_data.data;
                    mask_d[k]          = 1'b1;
                end
            end
            if (beat_close) begin
                wr_vld_d = 1'b1;
                lane_d   = '0;
            end else begin
                lane_d   = lane_q + LW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            cnt_q    <= '0;
            lane_q   <= '0;
            data_q   <= '0;
            mask_q   <= '0;
            wr_vld_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            lane_q   <= lane_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            wr_vld_q <= wr_vld_d;
            done_q   <= done_d;
        end
    end

    // The address is derived from the beat count. The count only moves on
    // acceptance, so the address holds steady under backpressure and wraps
    // naturally at 2^ADDR_W.
    assign o_wr_addr    = base_q + (ADDR_W'(cnt_q) << BEAT_SHIFT);
    assign o_ofm_ready  = ofm_rdy;
    assign o_wr_valid   = wr_vld_q;
    assign o_wr_data    = data_q;
    assign o_wr_mask    = mask_q;
    assign o_done       = done_q;
    assign o_beat_count = cnt_q;

endmodule
